i2c_slave_gen: RTL and testbench

I2C_SLAVE_GEN -- requirements
Module: i2c_slave_gen

---
 rtl/i2c_slave_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_slave_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_gen.sv
// I2C slave: synchronised bus front end, address match, master-write receive
// and master-read transmit fed from a small TX FIFO.
module i2c_slave_gen #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b1111000,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               scl,
    input  logic                               sda_in,
    input  logic                               write_enable,
    input  logic [7:0]                         write_data,
    output logic                               sda_out,
    output logic                               fifo_empty,
    output logic                               fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic [7:0]                         rx_data,
    output logic                               rx_valid,
    output logic                               busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACKCHK, RX_BYTE, RX_ACK, WAIT_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign sda_rise  =  sda_s & ~sda_prev_q;
    assign sda_fall  = ~sda_s &  sda_prev_q;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    // TX FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop, pop_ok, push_ok;
    logic [7:0]    fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign fifo_head  = mem_q[rd_ptr_q];
    assign pop_ok     = pop && !fifo_empty;
    assign push_ok    = write_enable && (!fifo_full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; clearing the pointers and count already empties the FIFO.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= write_data;
    end

    // Protocol FSM
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d, ack_drv_q, ack_drv_d, mack_q, mack_d;
    logic       sda_out_q, sda_out_d, rx_valid_q, rx_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            ack_drv_q  <= 1'b0;
            mack_q     <= 1'b0;
            sda_out_q  <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            ack_drv_q  <= ack_drv_d;
            mack_q     <= mack_d;
            sda_out_q  <= sda_out_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        ack_drv_d  = ack_drv_q;
        mack_d     = mack_q;
        sda_out_d  = sda_out_q;
        rx_valid_d = 1'b0;
        pop        = 1'b0;

        if (stop_det) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_out_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d      = sda_s;
                        ack_drv_d = 1'b0;
                        state_d   = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                // First fall opens the ACK bit, second fall closes it.
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_drv_q) begin
                        if (rw_q && fifo_empty) begin
                            sda_out_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end else begin
                            sda_out_d = 1'b0;
                            ack_drv_d = 1'b1;
                        end
                    end else if (rw_q) begin
                        pop       = 1'b1;
                        shift_d   = fifo_head;
                        sda_out_d = fifo_head[7];
                        bit_cnt_d = '0;
                        state_d   = TX_BYTE;
                    end else begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RX_BYTE;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_out_d = 1'b1;
                        state_d   = TX_ACKCHK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_out_d = shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                TX_ACKCHK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (mack_q && !fifo_empty) begin
                            pop       = 1'b1;
                            shift_d   = fifo_head;
                            sda_out_d = fifo_head[7];
                            bit_cnt_d = '0;
                            state_d   = TX_BYTE;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_valid_d = 1'b1;
                        ack_drv_d  = 1'b0;
                        state_d    = RX_ACK;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    if (!ack_drv_q) begin
                        sda_out_d = 1'b0;
                        ack_drv_d = 1'b1;
                    end else begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RX_BYTE;
                    end
                end
                WAIT_STOP: sda_out_d = 1'b1;
                default:   state_d   = IDLE;
            endcase
        end
    end

    assign sda_out  = sda_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_gen.sv
// Directed bench for i2c_slave_gen: a bit-banged master on a wired-AND SDA line.
module tb_i2c_slave_gen;

    localparam int Q = 4;  // clk cycles per quarter of an SCL bit

    logic       clk = 1'b0;
    logic       rst, scl, m_sda, write_enable;
    logic [7:0] write_data;
    logic       sda_in, sda_out, fifo_empty, fifo_full, rx_valid, busy;
    logic [2:0] fifo_count;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;
    int low_cnt  = 0;
    int rxv_cnt  = 0;

    assign sda_in = m_sda & sda_out;

    i2c_slave_gen dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl),
        .sda_in      (sda_in),
        .write_enable(write_enable),
        .write_data  (write_data),
        .sda_out     (sda_out),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sda_out === 1'b0) low_cnt++;
        if (rx_valid === 1'b1) rxv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        write_enable = 1'b1;
        write_data   = b;
        wait_clk(1);
        write_enable = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        m_sda = b;    wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        seen  = sda_in;
        wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], b);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, b);
            d[i] = b;
        end
        bit_xfer(ack_bit, b);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         base;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        write_enable = 1'b0; write_data = 8'h00;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Master read of one byte
        push(8'hA5);
        check("t1_count", fifo_count, 3'd1);
        check("t1_empty_pre", fifo_empty, 1'b0);
        bus_start();
        check("t1_busy", busy, 1'b1);
        write_byte(8'hF1, ack);
        check("t1_addr_ack", ack, 1'b0);
        read_byte(1'b1, d);
        check("t1_tx_byte", d, 8'hA5);
        check("t1_empty_post", fifo_empty, 1'b1);
        bus_stop();
        wait_clk(4);
        check("t1_busy_after_stop", busy, 1'b0);

        // Address mismatch: slave never pulls SDA low
        base = low_cnt;
        bus_start();
        write_byte(8'hE1, ack);
        check("t2_nack", ack, 1'b1);
        check("t2_busy_wait_stop", busy, 1'b1);
        bus_stop();
        wait_clk(4);
        check("t2_sda_low_cycles", low_cnt - base, 0);
        check("t2_busy_after_stop", busy, 1'b0);

        // Master write of one data byte
        base = rxv_cnt;
        bus_start();
        write_byte(8'hF0, ack);
        check("t3_addr_ack", ack, 1'b0);
        write_byte(8'h3C, ack);
        check("t3_data_ack", ack, 1'b0);
        check("t3_rx_data", rx_data, 8'h3C);
        check("t3_rx_valid_pulses", rxv_cnt - base, 1);
        bus_stop();
        wait_clk(4);

        // Overfill, then a push that coincides with the first pop while full
        write_enable = 1'b1;
        write_data = 8'h11; wait_clk(1);
        write_data = 8'h22; wait_clk(1);
        write_data = 8'h33; wait_clk(1);
        write_data = 8'h44; wait_clk(1);
        write_data = 8'h55; wait_clk(1);
        check("t4_full", fifo_full, 1'b1);
        check("t4_count_full", fifo_count, 3'd4);
        write_data = 8'h66;
        wait_clk(4);
        check("t4_count_held", fifo_count, 3'd4);
        bus_start();
        write_byte(8'hF1, ack);
        write_enable = 1'b0;
        check("t4_addr_ack", ack, 1'b0);
        check("t4_count_push_pop", fifo_count, 3'd4);
        read_byte(1'b0, d); check("t4_byte1", d, 8'h11);
        read_byte(1'b0, d); check("t4_byte2", d, 8'h22);
        read_byte(1'b0, d); check("t4_byte3", d, 8'h33);
        read_byte(1'b0, d); check("t4_byte4", d, 8'h44);
        read_byte(1'b1, d); check("t4_byte5", d, 8'h66);
        check("t4_empty", fifo_empty, 1'b1);
        bus_stop();
        wait_clk(4);

        // Read with empty FIFO, then repeated START once loaded
        bus_start();
        write_byte(8'hF1, ack);
        check("t5_empty_nack", ack, 1'b1);
        check("t5_busy", busy, 1'b1);
        push(8'h5A);
        bus_start();
        write_byte(8'hF1, ack);
        check("t5_rs_ack", ack, 1'b0);
        read_byte(1'b1, d);
        check("t5_tx_byte", d, 8'h5A);
        bus_stop();
        wait_clk(4);

        // Reset during the 4th transmitted bit (0xC3 bit4 = 0)
        push(8'hC3);
        push(8'h99);
        bus_start();
        write_byte(8'hF1, ack);
        check("t6_addr_ack", ack, 1'b0);
        check("t6_count_pre", fifo_count, 3'd1);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, b);
        check("t6_bit4_driven", sda_out, 1'b0);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("t6_sda_out", sda_out, 1'b1);
        check("t6_count", fifo_count, 3'd0);
        check("t6_empty", fifo_empty, 1'b1);
        check("t6_idle", busy, 1'b0);
        base = low_cnt;
        bit_xfer(1'b1, b);
        bus_stop();
        wait_clk(4);
        check("t6_sda_released", low_cnt - base, 0);
        check("t6_busy_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
